lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255; maximum cycles to wait for mem_ack_i before aborting.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request valid; sampled only in IDLE.
REQ-005 ld_en_i  input  1  request is a load.
REQ-006 st_en_i  input  1  request is a store.
REQ-007 funct3_i  input  3  access size/sign (RV32I encoding).
REQ-008 rs1_data_i  input  32  base address operand from register file.
REQ-009 rs2_data_i  input  32  store data from register file.
REQ-010 imm_i  input  32  sign-extended offset.
REQ-011 rd_addr_i  input  5  load destination register.
REQ-012 busy_o  output  1  high whenever state is not IDLE.
REQ-013 done_o  output  1  one-cycle completion pulse.
REQ-014 err_o  output  1  one-cycle pulse; misaligned, illegal, or timed-out request.
REQ-015 rd_addr_o, rd_data_o, rd_wren_o  output  5/32/1  write port toward the register file.
REQ-016 mem_req_o, mem_we_o  output  1/1  data-memory request and write enable.
REQ-017 mem_addr_o  output  32  word-aligned address (bits [1:0] = 0).
REQ-018 mem_wdata_o, mem_bmask_o  output  32/4  lane-placed store data and byte enables.
REQ-019 mem_ack_i, mem_rdata_i  input  1/32  memory completion and read word.

Function
REQ-020 States: IDLE, ACCESS, WB, ERR.
REQ-021 IDLE with start_i=1: latch addr = rs1_data_i+imm_i mod 2^32, plus funct3, rs2, rd_addr, direction.
REQ-022 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-023 Illegal funct3, ld_en_i=st_en_i, halfword with addr[0]=1, or word with addr[1:0]!=0 -> ERR; no memory request issued.
REQ-024 Legal request -> ACCESS; mem_req_o=1 from the cycle after accept through the ack cycle inclusive; addr/we/wdata/bmask stable throughout.
REQ-025 Store: mem_bmask_o = size mask (0001/0011/1111) shifted left by addr[1:0]; mem_wdata_o replicates byte/half across all lanes.
REQ-026 Store ack -> IDLE, done_o=1 that cycle; rd_wren_o stays 0.
REQ-027 Load ack -> capture lane addr[1:0] of mem_rdata_i, sign- or zero-extend per funct3, go to WB.
REQ-028 WB: rd_wren_o=1 and done_o=1 for exactly one cycle, then IDLE; rd_wren_o=0 if rd_addr is 0.
REQ-029 Load latency: accept at cycle 0, mem_req_o from cycle 1, ack at cycle k, rd_wren_o at cycle k+1.
REQ-030 ACCESS counter increments per cycle without ack; on reaching TIMEOUT_CYCLES, drop mem_req_o and go to ERR.
REQ-031 ERR: err_o=1 and done_o=1 for one cycle, then IDLE.
REQ-032 start_i outside IDLE and mem_ack_i outside ACCESS are ignored.
REQ-033 rd_data_o holds its last value outside WB.

Reset
REQ-034 rst_ni low asynchronously forces IDLE, counter 0, and every output 0, including mid-ACCESS (request abandoned, no write-back).
REQ-035 The first request is accepted on the first rising edge with rst_ni high.

Structure
REQ-036 Package lsu_pkg holds the state enum, load/store funct3 constants and the byte-mask constants.
REQ-037 Sub-module lsu_align (combinational) performs store lane replication/masking and load lane extraction/extension.

Verification
REQ-038 LW, rs1=0x100, imm=4, ack after 3 cycles with rdata 0xDEADBEEF -> mem_addr_o 0x104, rd_wren_o one cycle, rd_data_o 0xDEADBEEF.
REQ-039 LB, addr 0x103, rdata 0x80112233 -> rd_data_o 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-040 SH, addr 0x202, rs2 0x0000ABCD -> mem_bmask_o 1100, mem_wdata_o 0xABCDABCD, mem_addr_o 0x200, done_o on ack.
REQ-041 LW, addr 0x101 -> err_o pulse the cycle after accept, mem_req_o never asserted.
REQ-042 TIMEOUT_CYCLES=4, no ack -> mem_req_o for 4 cycles, then err_o pulse, busy_o low next cycle.
REQ-043 rst_ni low mid-ACCESS -> mem_req_o, busy_o, rd_wren_o fall to 0 immediately; no write-back after release.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                        |
// | Description : Shared types and constants for the load/store unit: FSM       |
// |               state enum, RV32I load/store funct3 codes, byte-enable masks  |
// |               and the funct3 legality helper.                                |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2,
    S_ERR    = 2'd3
  } lsu_state_e;

  // Load funct3 encodings
  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b100;
  localparam logic [2:0] C_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] C_SB  = 3'b000;
  localparam logic [2:0] C_SH  = 3'b001;
  localparam logic [2:0] C_SW  = 3'b010;

  // Byte-enable masks for lane 0; shifted left by the byte offset at use
  localparam logic [3:0] C_BMASK_B = 4'b0001;
  localparam logic [3:0] C_BMASK_H = 4'b0011;
  localparam logic [3:0] C_BMASK_W = 4'b1111;

  function automatic logic f_funct3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == C_LB) || (f3 == C_LH) || (f3 == C_LW) || (f3 == C_LBU) || (f3 == C_LHU);
    else
      return (f3 == C_SB) || (f3 == C_SH) || (f3 == C_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_align                                                      |
// | Description : Combinational lane logic. Stores: replicate byte/half across   |
// |               all lanes and build the byte-enable mask. Loads: pick the lane |
// |               addressed by addr[1:0] and sign/zero-extend it.               |
// | Revision    : 1.0 - initial release                                          |
// | Ports       : i_funct3     access size/sign                                  |
// |               i_addr_lo    byte offset within the word                       |
// |               i_store_data raw store operand                                 |
// |               i_rdata      memory read word                                  |
// |               o_wdata      lane-replicated store data                        |
// |               o_bmask      byte enables                                      |
// |               o_load_data  extended load result                              |
// +----------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wdata = i_store_data;
    o_bmask = C_BMASK_W;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_bmask = C_BMASK_B << i_addr_lo;
      end
      2'b01: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_bmask = C_BMASK_H << i_addr_lo;
      end
      default: begin
        o_wdata = i_store_data;
        o_bmask = C_BMASK_W;
      end
    endcase
  end

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      C_LB:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      C_LH:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      C_LW:    o_load_data = w_shifted;
      C_LBU:   o_load_data = {24'd0, w_shifted[7:0]};
      C_LHU:   o_load_data = {16'd0, w_shifted[15:0]};
      default: o_load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu                                                            |
// | Description : RV32I load/store unit. Accepts one request in IDLE, checks     |
// |               legality/alignment, drives a single-outstanding memory access  |
// |               with timeout, and writes load results back to the regfile.    |
// | Revision    : 1.0 - initial release                                          |
// | Ports       : clk_i/rst_ni           clock, async active-low reset          |
// |               start_i..rd_addr_i     request from the pipeline               |
// |               busy_o/done_o/err_o    status                                  |
// |               rd_addr_o/rd_data_o/rd_wren_o  regfile write port             |
// |               mem_*                  data-memory request/response            |
// +----------------------------------------------------------------------------+
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        ld_en_i,
  input  logic        st_en_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wren_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_bmask_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // The counter only needs to reach TIMEOUT_CYCLES-1: the ack-less cycle that
  // sees that value is the last one the request is held.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       r_state;
  lsu_state_e       w_state_nxt;
  logic [31:0]      r_addr;
  logic [2:0]       r_funct3;
  logic [31:0]      r_store_data;
  logic [4:0]       r_rd;
  logic             r_is_load;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rd_data;

  logic [31:0]      w_req_addr;
  logic             w_req_ok;
  logic             w_misaligned;
  logic [31:0]      w_wdata;
  logic [3:0]       w_bmask;
  logic [31:0]      w_load_data;

  assign w_req_addr = rs1_data_i + imm_i;

  // Alignment depends only on the size bits; illegal sizes are caught by the
  // funct3 check instead.
  assign w_misaligned = ((funct3_i[1:0] == 2'b01) && w_req_addr[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (w_req_addr[1:0] != 2'b00));

  assign w_req_ok = (ld_en_i ^ st_en_i) && f_funct3_legal(ld_en_i, funct3_i) && !w_misaligned;

  lsu_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (mem_rdata_i),
    .o_wdata      (w_wdata),
    .o_bmask      (w_bmask),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_is_load    <= 1'b0;
      r_cnt        <= '0;
      r_rd_data    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start_i) begin
        r_addr       <= w_req_addr;
        r_funct3     <= funct3_i;
        r_store_data <= rs2_data_i;
        r_rd         <= rd_addr_i;
        r_is_load    <= ld_en_i;
        r_cnt        <= '0;
      end else if (r_state == S_ACCESS && !mem_ack_i) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_ACCESS && mem_ack_i && r_is_load)
        r_rd_data <= w_load_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    err_o       = 1'b0;
    rd_wren_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_bmask_o = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i)
          w_state_nxt = w_req_ok ? S_ACCESS : S_ERR;
      end
      S_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = !r_is_load;
        mem_addr_o  = {r_addr[31:2], 2'b00};
        mem_bmask_o = w_bmask;
        mem_wdata_o = r_is_load ? 32'd0 : w_wdata;
        if (mem_ack_i) begin
          if (r_is_load) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_IDLE;
            done_o      = 1'b1;
          end
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = S_ERR;
        end
      end
      S_WB: begin
        done_o      = 1'b1;
        rd_wren_o   = (r_rd != 5'd0);
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        done_o      = 1'b1;
        err_o       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_addr_o = r_rd;
  assign rd_data_o = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu                                                         |
// | Description : Self-checking bench for lsu with directed and random requests  |
// |               against an arithmetic reference model.                        |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_lsu;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        ld_en_i = 1'b0;
  logic        st_en_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [31:0] imm_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        busy_o, done_o, err_o, rd_wren_o, mem_req_o, mem_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_bmask_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ld_en_i(ld_en_i),
    .st_en_i(st_en_i), .funct3_i(funct3_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .rd_wren_o(rd_wren_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_bmask_o(mem_bmask_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (ld == st) return 1'b0;
    if (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    if (st && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
    return (a % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_bmask(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s;
    s = m_size(f3);
    return 32'(((32'd1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (m_size(f3))
      1:       return 32'(d % 256) * 32'h01010101;
      2:       return 32'(d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    longint unsigned v, span;
    v    = 64'(rdata) >> (8 * (a % 4));
    span = 64'd1 << (8 * m_size(f3));
    v    = v % span;
    if (!f3[2] && v >= span / 2) v = v - span;  // two's complement wrap = sign extension
    return 32'(v);
  endfunction

  // Inputs that must be ignored while the unit is busy
  task automatic noise();
    start_i    = 1'($urandom);
    ld_en_i    = 1'($urandom);
    st_en_i    = 1'($urandom);
    funct3_i   = 3'($urandom);
    rs1_data_i = $urandom;
    imm_i      = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
  endtask

  task automatic do_req(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [4:0] rd, input int waits, input logic [31:0] rdata);
    logic [31:0] a, exp_ld;
    bit ok;
    a      = rs1 + imm;
    ok     = m_legal(ld, st, f3, a);
    exp_ld = m_load(f3, a, rdata);
    start_i = 1'b1; ld_en_i = ld; st_en_i = st; funct3_i = f3;
    rs1_data_i = rs1; imm_i = imm; rs2_data_i = rs2; rd_addr_i = rd;
    @(posedge clk_i); #1;
    noise();
    if (!ok) begin
      chk({tag, ".err"}, 32'(err_o), 1);
      chk({tag, ".err_done"}, 32'(done_o), 1);
      chk({tag, ".err_noreq"}, 32'(mem_req_o), 0);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk({tag, ".err_idle"}, 32'(busy_o), 0);
      chk({tag, ".err_once"}, 32'(err_o), 0);
      return;
    end
    for (int i = 0; i < TIMEOUT; i++) begin
      chk({tag, ".req"}, 32'(mem_req_o), 1);
      chk({tag, ".addr"}, mem_addr_o, a & ~32'h3);
      chk({tag, ".we"}, 32'(mem_we_o), 32'(st));
      chk({tag, ".busy"}, 32'(busy_o), 1);
      if (st) begin
        chk({tag, ".bmask"}, 32'(mem_bmask_o), m_bmask(f3, a));
        chk({tag, ".wdata"}, mem_wdata_o, m_wdata(f3, rs2));
      end
      chk({tag, ".nodone"}, 32'(done_o), 0);
      if (i == waits) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdata; #1;
        chk({tag, ".ackdone"}, 32'(done_o), 32'(st));
        chk({tag, ".ackwren"}, 32'(rd_wren_o), 0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        if (ld) begin
          mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
          chk({tag, ".wren"}, 32'(rd_wren_o), 32'(rd != 5'd0));
          chk({tag, ".wbdone"}, 32'(done_o), 1);
          chk({tag, ".rdata"}, rd_data_o, exp_ld);
          chk({tag, ".rdaddr"}, 32'(rd_addr_o), 32'(rd));
          chk({tag, ".wbnoreq"}, 32'(mem_req_o), 0);
          @(posedge clk_i); #1;
          mem_ack_i = 1'b0;
        end
        start_i = 1'b0;
        chk({tag, ".idle"}, 32'(busy_o), 0);
        chk({tag, ".wren_once"}, 32'(rd_wren_o), 0);
        chk({tag, ".done_once"}, 32'(done_o), 0);
        if (ld) chk({tag, ".hold"}, rd_data_o, exp_ld);
        return;
      end
      @(posedge clk_i); #1;
      noise();
    end
    chk({tag, ".to_err"}, 32'(err_o), 1);
    chk({tag, ".to_done"}, 32'(done_o), 1);
    chk({tag, ".to_noreq"}, 32'(mem_req_o), 0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, ".to_idle"}, 32'(busy_o), 0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};

    // Reset state
    #1;
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.done", 32'(done_o), 0);
    chk("rst.err", 32'(err_o), 0);
    chk("rst.wren", 32'(rd_wren_o), 0);
    chk("rst.rdaddr", 32'(rd_addr_o), 0);
    chk("rst.rddata", rd_data_o, 0);
    chk("rst.req", 32'(mem_req_o), 0);
    chk("rst.we", 32'(mem_we_o), 0);
    chk("rst.addr", mem_addr_o, 0);
    chk("rst.wdata", mem_wdata_o, 0);
    chk("rst.bmask", 32'(mem_bmask_o), 0);
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_ni = 1'b1;

    // Directed (first one accepted on the first edge after reset release)
    do_req("lw_dead",  1, 0, 3'b010, 32'h100, 32'd4, 0, 5'd5, 2, 32'hDEADBEEF);
    do_req("lb_neg",   1, 0, 3'b000, 32'h100, 32'd3, 0, 5'd7, 0, 32'h80112233);
    do_req("lbu",      1, 0, 3'b100, 32'h100, 32'd3, 0, 5'd7, 1, 32'h80112233);
    do_req("sh",       0, 1, 3'b001, 32'h200, 32'd2, 32'h0000ABCD, 5'd0, 1, 0);
    do_req("sb",       0, 1, 3'b000, 32'h300, 32'd1, 32'h12345678, 5'd0, 0, 0);
    do_req("lhu",      1, 0, 3'b101, 32'h100, 32'd2, 0, 5'd9, 3, 32'h80010000);
    do_req("lw_rd0",   1, 0, 3'b010, 32'h40, 32'd0, 0, 5'd0, 0, 32'h12345678);
    do_req("lw_mis",   1, 0, 3'b010, 32'h100, 32'd1, 0, 5'd3, 0, 0);
    do_req("lh_mis",   1, 0, 3'b001, 32'h100, 32'd3, 0, 5'd3, 0, 0);
    do_req("ld_f3_3",  1, 0, 3'b011, 32'h100, 32'd0, 0, 5'd3, 0, 0);
    do_req("st_f3_4",  0, 1, 3'b100, 32'h100, 32'd0, 0, 5'd3, 0, 0);
    do_req("both",     1, 1, 3'b010, 32'h100, 32'd0, 0, 5'd3, 0, 0);
    do_req("neither",  0, 0, 3'b010, 32'h100, 32'd0, 0, 5'd3, 0, 0);
    do_req("timeout",  1, 0, 3'b010, 32'h100, 32'd0, 0, 5'd3, TIMEOUT, 0);
    do_req("st_to",    0, 1, 3'b010, 32'h100, 32'd0, 32'h5, 5'd3, TIMEOUT, 0);

    // Random requests
    for (int i = 0; i < 40; i++) begin
      bit ld, st;
      logic [2:0] f3;
      int sel;
      sel = int'($urandom % 10);
      ld  = (sel < 5);
      st  = !ld;
      if (sel == 9) begin ld = 1'($urandom); st = ld; end
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else if (ld)            f3 = ld_f3[$urandom % 5];
      else                    f3 = st_f3[$urandom % 3];
      do_req($sformatf("rnd%0d", i), ld, st, f3, $urandom & ~32'h3, $urandom % 8,
             $urandom, 5'($urandom), int'($urandom % (TIMEOUT + 1)), $urandom);
    end

    // Reset in the middle of an access
    start_i = 1'b1; ld_en_i = 1'b1; st_en_i = 1'b0; funct3_i = 3'b010;
    rs1_data_i = 32'h400; imm_i = 0; rd_addr_i = 5'd4;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("mid.req_before", 32'(mem_req_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid.req", 32'(mem_req_o), 0);
    chk("mid.busy", 32'(busy_o), 0);
    chk("mid.wren", 32'(rd_wren_o), 0);
    chk("mid.rddata", rd_data_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post.busy", 32'(busy_o), 0);
    chk("post.wren", 32'(rd_wren_o), 0);
    chk("post.done", 32'(done_o), 0);
    @(posedge clk_i); #1;
    chk("post.wren2", 32'(rd_wren_o), 0);
    chk("post.rddata", rd_data_o, 0);
    mem_ack_i = 1'b0;

    do_req("recover", 1, 0, 3'b001, 32'h500, 32'd2, 0, 5'd11, 1, 32'hF00D1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
